// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Define ALU_MC_DIV_EN to build the divider; without it DIV decodes as an illegal opcode.
module alu_mc #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       oper,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             err
);

   localparam int unsigned   CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       opd_q, opd_d, res_q, res_d, hi_q, hi_d;
   logic                   err_q, err_d, neg_q, neg_d;

   logic                   accept, multi;
   logic [WIDTH-1:0]       mag_a, mag_b, sc_res, sc_hi;
   logic                   sc_err;
   logic [SHW-1:0]         shamt;
   logic signed [WIDTH-1:0] sra;
   logic [WIDTH:0]         mul_sum;
   logic [2*WIDTH-1:0]     mul_nxt, prod;

   assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == StDone);
   assign result    = res_q;
   assign hi        = hi_q;
   assign err       = err_q;

   assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
   assign mag_b = (sign && b[WIDTH-1]) ? -b : b;
   assign shamt = a[SHW-1:0];
   assign sra   = $signed(b) >>> shamt;

   // Shift-add over {hi, lo}: the multiplier sits in the low half and drains out as hi fills.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
   assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod    = neg_q ? -mul_nxt : mul_nxt;

`ifdef ALU_MC_DIV_EN
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

   logic                   div_q, div_d, rneg_q, rneg_d, is_div;
   logic [WIDTH:0]         div_shf, div_dif;
   logic [2*WIDTH-1:0]     div_nxt;
   logic [WIDTH-1:0]       quo, rem;

   // Restoring step on {remainder, dividend/quotient}.
   assign div_shf = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_dif = div_shf - {1'b0, opd_q};
   assign div_nxt = div_dif[WIDTH] ? {div_shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign quo     = neg_q  ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
   assign rem     = rneg_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_err = 1'b0;
      multi  = 1'b0;
`ifdef ALU_MC_DIV_EN
      is_div = 1'b0;
`endif
      case (oper)
         4'd0:  sc_res = a + b;
         4'd1:  sc_res = a - b;
         4'd2:  sc_res = {{(WIDTH-1){1'b0}}, (sign ? ($signed(a) < $signed(b)) : (a < b))};
         4'd3:  sc_res = a & b;
         4'd4:  sc_res = a | b;
         4'd5:  sc_res = a ^ b;
         4'd6:  sc_res = ~(a | b);
         4'd7:  sc_res = b << shamt;
         4'd8:  sc_res = sign ? sra : (b >> shamt);
         4'd9:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         4'd10: multi  = 1'b1;
`ifdef ALU_MC_DIV_EN
         4'd11: begin
            if (b == '0) begin
               sc_res = '1;
               sc_hi  = a;
               sc_err = 1'b1;
            end else if (sign && (a == MinNeg) && (b == '1)) begin
               sc_res = a;
            end else begin
               multi  = 1'b1;
               is_div = 1'b1;
            end
         end
`endif
         default: sc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      res_d   = res_q;
      hi_d    = hi_q;
      err_d   = err_q;
      neg_d   = neg_q;
`ifdef ALU_MC_DIV_EN
      div_d   = div_q;
      rneg_d  = rneg_q;
`endif
      unique case (state_q)
         StBusy: begin
            cnt_d = cnt_q + 1'b1;
`ifdef ALU_MC_DIV_EN
            acc_d = div_q ? div_nxt : mul_nxt;
`else
            acc_d = mul_nxt;
`endif
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               err_d   = 1'b0;
`ifdef ALU_MC_DIV_EN
               if (div_q) begin
                  res_d = quo;
                  hi_d  = rem;
               end else
`endif
               begin
                  res_d = prod[WIDTH-1:0];
                  hi_d  = prod[2*WIDTH-1:WIDTH];
               end
            end
         end
         StDone: if (out_ready) state_d = StIdle;
         default: ;
      endcase

      if (accept) begin
         cnt_d = '0;
         neg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
         if (multi) begin
            state_d = StBusy;
`ifdef ALU_MC_DIV_EN
            div_d  = is_div;
            rneg_d = sign & a[WIDTH-1];
            if (is_div) begin
               acc_d = {{WIDTH{1'b0}}, mag_a};
               opd_d = mag_b;
            end else
`endif
            begin
               acc_d = {{WIDTH{1'b0}}, mag_b};
               opd_d = mag_a;
            end
         end else begin
            state_d = StDone;
            res_d   = sc_res;
            hi_d    = sc_hi;
            err_d   = sc_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         err_q   <= 1'b0;
         neg_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
         neg_q   <= neg_d;
`ifdef ALU_MC_DIV_EN
         div_q   <= div_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32) with an expectation queue and immediate assertions.
// DIV expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

   logic        clk, rst_n, in_valid, in_ready, sign, out_valid, out_ready, err;
   logic [31:0] a, b, result, hi;
   logic [3:0]  oper;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .oper      (oper),
      .sign      (sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .hi        (hi),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] top,
                        input logic ts);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("issue_ready", 32'(in_ready), 32'd1);
      a = ta; b = tb; oper = top; sign = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; oper = 4'd0; sign = 1'b0;
   endtask

   // Counts cycles from acceptance to out_valid; notes any in_ready seen meanwhile.
   task automatic wait_out(output int lat, output bit rdy_seen);
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [3:0] top, input logic ts, input logic [31:0] er,
                         input logic [31:0] eh, input logic ee, input int el);
      exp_t e;
      int   lat;
      bit   rdy;
      exp_q.push_back('{res: er, hi: eh, err: ee, lat: el});
      issue(ta, tb, top, ts);
      wait_out(lat, rdy);
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      if (e.lat > 1) chk({tag, "_busy_ready"}, 32'(rdy), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int  lat;
      bit  rdy;
      bit  seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; oper = '0; sign = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 4'd0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1);
      run_op("sub_wrap", 32'h0, 32'h1, 4'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
      run_op("slt_s", 32'hFFFF_FFFF, 32'h1, 4'd2, 1'b1, 32'h1, 32'h0, 1'b0, 1);
      run_op("slt_u", 32'hFFFF_FFFF, 32'h1, 4'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1);
      run_op("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd3, 1'b0, 32'h0F00_0F00, 32'h0, 1'b0, 1);
      run_op("or", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd4, 1'b0, 32'hFFF0_FFF0, 32'h0, 1'b0, 1);
      run_op("xor", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd5, 1'b0, 32'hF0F0_F0F0, 32'h0, 1'b0, 1);
      run_op("nor", 32'hF0F0_F0F0, 32'h0F0F_0000, 4'd6, 1'b0, 32'h0000_0F0F, 32'h0, 1'b0, 1);
      run_op("sl_mask", 32'd36, 32'h1, 4'd7, 1'b0, 32'h10, 32'h0, 1'b0, 1);
      run_op("sr_log", 32'd4, 32'h8000_0000, 4'd8, 1'b0, 32'h0800_0000, 32'h0, 1'b0, 1);
      run_op("lui", 32'h0, 32'h1234_ABCD, 4'd9, 1'b0, 32'hABCD_0000, 32'h0, 1'b0, 1);
      run_op("mul_s", 32'hFFFF_FFFD, 32'd5, 4'd10, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 33);
      run_op("mul_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 1'b0, 32'h1, 32'hFFFF_FFFE, 1'b0, 33);
      run_op("illegal", 32'd1, 32'd2, 4'd13, 1'b0, 32'h0, 32'h0, 1'b1, 1);
`ifdef ALU_MC_DIV_EN
      run_op("div_s", 32'hFFFF_FFF9, 32'd2, 4'd11, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
      run_op("div_u", 32'd100, 32'd7, 4'd11, 1'b0, 32'd14, 32'd2, 1'b0, 33);
      run_op("div_zero", 32'd5, 32'd0, 4'd11, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
      run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1);
`else
      run_op("div_off", 32'd10, 32'd3, 4'd11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
`endif

      // Backpressure: result must hold while out_ready is low, then chain an ADD with no bubble.
      out_ready = 1'b0;
      exp_q.push_back('{res: 32'hF800_0000, hi: 32'h0, err: 1'b0, lat: 1});
      issue(32'd4, 32'h8000_0000, 4'd8, 1'b1);
      wait_out(lat, rdy);
      chk("sr_ari_latency", 32'(lat), 32'(exp_q[0].lat));
      for (int i = 0; i < 5; i++) begin
         chk("hold_result", result, exp_q[0].res);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_valid", 32'(out_valid), 32'd1);
         @(negedge clk);
      end
      void'(exp_q.pop_front());
      exp_q.push_back('{res: 32'd3, hi: 32'h0, err: 1'b0, lat: 1});
      out_ready = 1'b1;
      a = 32'd1; b = 32'd2; oper = 4'd0; sign = 1'b0; in_valid = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", result, exp_q[0].res);
      void'(exp_q.pop_front());
      @(negedge clk);

      // Reset in the middle of a MUL must abort it.
      issue(32'd7, 32'd9, 4'd10, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      run_op("post_rst_add", 32'd20, 32'd22, 4'd0, 1'b0, 32'd42, 32'h0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
